// File: rtl/ofifo_drain_pkg.sv
// ofifo_drain_pkg: shared state encoding and lane width for the OFIFO drain block
package ofifo_drain_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;
    localparam int LANE_W = 16;
endpackage

// File: rtl/ofifo_drain_if.sv
// ofifo_drain_if: OFIFO pop handshake plus psum SRAM write port
interface ofifo_drain_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_bw = 11
);
    logic                     ofifo_valid;
    logic [col*psum_bw-1:0]   ofifo_out;
    logic                     ofifo_rd;
    logic                     sram_cen;
    logic                     sram_wen;
    logic [addr_bw-1:0]       sram_addr;
    logic [col*psum_bw-1:0]   sram_d;
    modport master (
        input  ofifo_valid, ofifo_out,
        output ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d
    );
    modport slave (
        output ofifo_valid, ofifo_out,
        input  ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d
    );
endinterface

// File: rtl/ofifo_drain_relu.sv
// ofifo_drain_relu: per-lane combinational ReLU, negative two's-complement lanes forced to 0
module ofifo_drain_relu
    import ofifo_drain_pkg::*;
#(
    parameter int col     = 8,
    parameter int psum_bw = LANE_W
) (
    input  logic [col*psum_bw-1:0] d,
    output logic [col*psum_bw-1:0] q
);
    for (genvar i = 0; i < col; i++) begin : g_lane
        assign q[psum_bw*i +: psum_bw] = d[psum_bw*(i+1)-1] ? '0 : d[psum_bw*i +: psum_bw];
    end
endmodule

// File: rtl/ofifo_drain.sv
// ofifo_drain: pops OFIFO rows and writes them to psum SRAM at consecutive addresses.
// Optional macro OFIFO_DRAIN_RELU_EN clamps negative lanes to 0 on the pop path.
module ofifo_drain
    import ofifo_drain_pkg::*;
#(
    parameter int col     = 8,
    parameter int psum_bw = LANE_W,
    parameter int addr_bw = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] base_addr,
    input  logic [addr_bw-1:0] num_words,
    input  logic               hold,
    output logic               busy,
    output logic               done,
    ofifo_drain_if.master      bus
);
    state_t                 state, state_nx;
    logic [addr_bw-1:0]     rem_q, addr_q;
    logic [col*psum_bw-1:0] d_q, pop_d;
    logic                   wr_q, pop;

`ifdef OFIFO_DRAIN_RELU_EN
    ofifo_drain_relu #(.col(col), .psum_bw(psum_bw)) u_relu (
        .d(bus.ofifo_out),
        .q(pop_d)
    );
`else
    assign pop_d = bus.ofifo_out;
`endif

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            IDLE:  state_nx = !start ? IDLE : (num_words == '0 ? DONE : DRAIN);
            DRAIN: begin
                pop      = bus.ofifo_valid && !hold && rem_q != '0;
                state_nx = (pop && rem_q == addr_bw'(1)) ? FLUSH : DRAIN;
            end
            FLUSH: state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Write stage is one cycle behind the pop; outputs come straight from registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            rem_q  <= '0;
            addr_q <= '0;
            d_q    <= '0;
            wr_q   <= 1'b0;
        end else begin
            state <= state_nx;
            wr_q  <= pop;
            if (pop) begin
                d_q   <= pop_d;
                rem_q <= rem_q - addr_bw'(1);
            end
            if (state == IDLE && start) begin
                addr_q <= base_addr;
                rem_q  <= num_words;
            end else if (wr_q) begin
                addr_q <= addr_q + addr_bw'(1);
            end
        end
    end

    assign bus.ofifo_rd  = pop;
    assign bus.sram_cen  = !wr_q;
    assign bus.sram_wen  = !wr_q;
    assign bus.sram_addr = addr_q;
    assign bus.sram_d    = d_q;
    assign busy          = state != IDLE;
    assign done          = state == DONE;
endmodule

// File: tb/tb_ofifo_drain.sv
// tb_ofifo_drain: randomized self-checking bench; the bench plays the OFIFO and watches the SRAM port.
module tb_ofifo_drain;
    localparam int COL = 8;
    localparam int PBW = 16;
    localparam int ABW = 11;
    localparam int W   = COL * PBW;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [ABW-1:0] base_addr = '0;
    logic [ABW-1:0] num_words = '0;
    logic           hold = 1'b0;
    logic           busy, done;

    ofifo_drain_if #(.col(COL), .psum_bw(PBW), .addr_bw(ABW)) bus ();

    ofifo_drain #(.col(COL), .psum_bw(PBW), .addr_bw(ABW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_words(num_words), .hold(hold), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [W-1:0] rows[$];
    int hd;
    int obs_addr[$];
    logic [W-1:0] obs_data[$];
    int obs_cyc[$];
    int pops, dones, done_cyc, rd_bad, wen_bad;
    bit timed_out;
    logic snap_rd, snap_cen, snap_wen, snap_busy, snap_done;
    logic [ABW-1:0] snap_addr;
    logic [W-1:0] snap_d;

    function automatic logic [W-1:0] rand_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: what the SRAM should receive for a popped row.
    function automatic logic [W-1:0] exp_row(input logic [W-1:0] r);
        logic [W-1:0] e = r;
`ifdef OFIFO_DRAIN_RELU_EN
        for (int k = 0; k < COL; k++)
            if ($signed(r[PBW*k +: PBW]) < 0) e[PBW*k +: PBW] = '0;
`endif
        return e;
    endfunction

    function automatic int exp_addr(input int base, input int i);
        return (base + i) % (1 << ABW);
    endfunction

    task automatic load_rows(input int n);
        rows.delete();
        for (int i = 0; i < n; i++) rows.push_back(rand_row());
    endtask

    task automatic drive_in(input int cyc, input int vmode, input int hmode, input int first_pop);
        bit have = hd < rows.size();
        bus.ofifo_valid = have && (vmode == 0 || (vmode == 1 && cyc % 2 == 0) ||
                                   (vmode == 2 && $urandom_range(0, 2) != 0));
        bus.ofifo_out   = have ? rows[hd] : '0;
        hold = (hmode == 1 && first_pop >= 0 && cyc > first_pop && cyc <= first_pop + 2) ||
               (hmode == 2 && $urandom_range(0, 3) == 0);
    endtask

    // Runs one drain; cycle 0 is the start cycle. Records pops, writes and done pulses.
    task automatic drain(input int base, input int n, input int vmode, input int hmode,
                         input int rst_at, input int budget);
        int cyc = 0, first_pop = -1;
        logic rd;
        bit fin = 0;
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        pops = 0; dones = 0; done_cyc = -1; rd_bad = 0; wen_bad = 0; timed_out = 0; hd = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = ABW'(base); num_words = ABW'(n);
        drive_in(0, vmode, hmode, -1);
        while (!fin) begin
            @(negedge clk);
            rd = bus.ofifo_rd;
            if (rd) begin
                pops++;
                if (first_pop < 0) first_pop = cyc;
                if (!bus.ofifo_valid) rd_bad++;
            end
            if (!bus.sram_cen) begin
                if (bus.sram_wen) wen_bad++;
                obs_addr.push_back(int'(bus.sram_addr));
                obs_data.push_back(bus.sram_d);
                obs_cyc.push_back(cyc);
            end
            if (done) begin dones++; done_cyc = cyc; end
            @(posedge clk); #1;
            start = 1'b0;
            if (rd) hd++;
            cyc++;
            if (rst_at > 0 && pops == rst_at) begin
                reset = 1'b0;
                #1;
                snap_rd = bus.ofifo_rd; snap_cen = bus.sram_cen; snap_wen = bus.sram_wen;
                snap_busy = busy; snap_done = done; snap_addr = bus.sram_addr; snap_d = bus.sram_d;
                fin = 1;
            end else begin
                drive_in(cyc, vmode, hmode, first_pop);
                if (cyc >= budget && dones == 0) timed_out = 1;
                fin = (dones > 0 && cyc > done_cyc + 2) || cyc >= budget;
            end
        end
        bus.ofifo_valid = 1'b0; hold = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.ofifo_valid = 1'b1; bus.ofifo_out = rand_row(); start = 1'b1; num_words = 5;
        repeat (3) @(negedge clk);
        checks += 7;
        if (bus.ofifo_rd !== 1'b0) begin errors++; $display("FAIL reset_rd got=%b exp=0", bus.ofifo_rd); end
        if (bus.sram_cen !== 1'b1) begin errors++; $display("FAIL reset_cen got=%b exp=1", bus.sram_cen); end
        if (bus.sram_wen !== 1'b1) begin errors++; $display("FAIL reset_wen got=%b exp=1", bus.sram_wen); end
        if (bus.sram_addr !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", bus.sram_addr); end
        if (bus.sram_d !== '0) begin errors++; $display("FAIL reset_d got=%h exp=0", bus.sram_d); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b0; bus.ofifo_valid = 1'b0;
    endtask

    task automatic test_basic();
        load_rows(6);
        drain(12'h010, 4, 0, 0, 0, 200);
        checks += 6;
        if (timed_out) begin errors++; $display("FAIL basic_timeout got=no_done exp=done"); end
        if (obs_addr.size() != 4) begin errors++; $display("FAIL basic_writes got=%0d exp=4", obs_addr.size()); end
        if (pops != 4) begin errors++; $display("FAIL basic_pops got=%0d exp=4", pops); end
        if (dones != 1) begin errors++; $display("FAIL basic_dones got=%0d exp=1", dones); end
        if (wen_bad != 0) begin errors++; $display("FAIL basic_wen got=%0d exp=0", wen_bad); end
        if (obs_cyc.size() == 4 && (done_cyc != obs_cyc[3] + 1 || obs_cyc[3] - obs_cyc[0] != 3))
            begin errors++; $display("FAIL basic_timing got=done@%0d exp=done@%0d", done_cyc, obs_cyc[3] + 1); end
        for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
            checks += 2;
            if (obs_addr[i] != 16'h010 + i) begin errors++; $display("FAIL basic_addr%0d got=%h exp=%h", i, obs_addr[i], 16'h010 + i); end
            if (obs_data[i] !== exp_row(rows[i])) begin errors++; $display("FAIL basic_data%0d got=%h exp=%h", i, obs_data[i], exp_row(rows[i])); end
        end
    endtask

    task automatic test_zero();
        load_rows(2);
        drain($urandom_range(0, 2047), 0, 0, 0, 0, 50);
        checks += 4;
        if (dones != 1) begin errors++; $display("FAIL zero_dones got=%0d exp=1", dones); end
        if (done_cyc != 1) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=1", done_cyc); end
        if (pops != 0) begin errors++; $display("FAIL zero_pops got=%0d exp=0", pops); end
        if (obs_addr.size() != 0) begin errors++; $display("FAIL zero_writes got=%0d exp=0", obs_addr.size()); end
    endtask

    task automatic test_stall();
        int base = $urandom_range(0, 2000);
        load_rows(5);
        drain(base, 3, 0, 1, 0, 200);
        checks += 3;
        if (obs_addr.size() != 3) begin errors++; $display("FAIL stall_writes got=%0d exp=3", obs_addr.size()); end
        if (pops != 3) begin errors++; $display("FAIL stall_pops got=%0d exp=3", pops); end
        if (obs_cyc.size() == 3 && (obs_cyc[1] - obs_cyc[0] != 3 || obs_cyc[2] - obs_cyc[1] != 1))
            begin errors++; $display("FAIL stall_gap got=%0d,%0d exp=3,1", obs_cyc[1] - obs_cyc[0], obs_cyc[2] - obs_cyc[1]); end
        for (int i = 0; i < obs_addr.size() && i < 3; i++) begin
            checks += 2;
            if (obs_addr[i] != exp_addr(base, i)) begin errors++; $display("FAIL stall_addr%0d got=%h exp=%h", i, obs_addr[i], exp_addr(base, i)); end
            if (obs_data[i] !== exp_row(rows[i])) begin errors++; $display("FAIL stall_data%0d got=%h exp=%h", i, obs_data[i], exp_row(rows[i])); end
        end
    endtask

    task automatic test_wrap();
        int ea[4] = '{12'h7FE, 12'h7FF, 12'h000, 12'h001};
        load_rows(6);
        drain(12'h7FE, 4, 1, 0, 0, 200);
        checks += 4;
        if (obs_addr.size() != 4) begin errors++; $display("FAIL wrap_writes got=%0d exp=4", obs_addr.size()); end
        if (pops != 4) begin errors++; $display("FAIL wrap_pops got=%0d exp=4", pops); end
        if (rd_bad != 0) begin errors++; $display("FAIL wrap_pop_invalid got=%0d exp=0", rd_bad); end
        if (dones != 1) begin errors++; $display("FAIL wrap_dones got=%0d exp=1", dones); end
        for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
            checks += 2;
            if (obs_addr[i] != ea[i]) begin errors++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, obs_addr[i], ea[i]); end
            if (obs_data[i] !== exp_row(rows[i])) begin errors++; $display("FAIL wrap_data%0d got=%h exp=%h", i, obs_data[i], exp_row(rows[i])); end
        end
    endtask

    task automatic test_reset_mid();
        int base = $urandom_range(0, 2047);
        load_rows(7);
        drain(base, 5, 0, 0, 2, 200);
        checks += 9;
        if (snap_rd !== 1'b0) begin errors++; $display("FAIL midrst_rd got=%b exp=0", snap_rd); end
        if (snap_cen !== 1'b1) begin errors++; $display("FAIL midrst_cen got=%b exp=1", snap_cen); end
        if (snap_wen !== 1'b1) begin errors++; $display("FAIL midrst_wen got=%b exp=1", snap_wen); end
        if (snap_addr !== '0) begin errors++; $display("FAIL midrst_addr got=%h exp=0", snap_addr); end
        if (snap_d !== '0) begin errors++; $display("FAIL midrst_d got=%h exp=0", snap_d); end
        if (snap_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", snap_busy); end
        if (snap_done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", snap_done); end
        if (obs_addr.size() != 1) begin errors++; $display("FAIL midrst_writes got=%0d exp=1", obs_addr.size()); end
        if (obs_addr.size() == 1 && obs_addr[0] != base) begin errors++; $display("FAIL midrst_addr0 got=%h exp=%h", obs_addr[0], base); end
        @(posedge clk); #1;
        reset = 1'b1;
        base = $urandom_range(0, 2047);
        load_rows(7);
        drain(base, 5, 0, 0, 0, 200);
        checks += 2;
        if (obs_addr.size() != 5) begin errors++; $display("FAIL midrst_fresh_writes got=%0d exp=5", obs_addr.size()); end
        if (dones != 1) begin errors++; $display("FAIL midrst_fresh_dones got=%0d exp=1", dones); end
        for (int i = 0; i < obs_addr.size() && i < 5; i++) begin
            checks += 2;
            if (obs_addr[i] != exp_addr(base, i)) begin errors++; $display("FAIL midrst_fresh_addr%0d got=%h exp=%h", i, obs_addr[i], exp_addr(base, i)); end
            if (obs_data[i] !== exp_row(rows[i])) begin errors++; $display("FAIL midrst_fresh_data%0d got=%h exp=%h", i, obs_data[i], exp_row(rows[i])); end
        end
    endtask

    task automatic test_relu();
        logic [W-1:0] r = rand_row();
        logic [PBW-1:0] lane0_exp;
`ifdef OFIFO_DRAIN_RELU_EN
        lane0_exp = 16'h0000;
`else
        lane0_exp = 16'hFFF0;
`endif
        r[15:0] = 16'hFFF0; r[31:16] = 16'h0005;
        rows.delete(); rows.push_back(r); rows.push_back(rand_row());
        drain($urandom_range(0, 2047), 1, 0, 0, 0, 50);
        checks += 4;
        if (obs_data.size() != 1) begin errors++; $display("FAIL relu_writes got=%0d exp=1", obs_data.size()); end
        if (obs_data.size() == 1 && obs_data[0][15:0] !== lane0_exp) begin errors++; $display("FAIL relu_lane0 got=%h exp=%h", obs_data[0][15:0], lane0_exp); end
        if (obs_data.size() == 1 && obs_data[0][31:16] !== 16'h0005) begin errors++; $display("FAIL relu_lane1 got=%h exp=0005", obs_data[0][31:16]); end
        if (obs_data.size() == 1 && obs_data[0] !== exp_row(r)) begin errors++; $display("FAIL relu_row got=%h exp=%h", obs_data[0], exp_row(r)); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int base = $urandom_range(0, 2047);
            int n = $urandom_range(1, 12);
            load_rows(n + $urandom_range(0, 3));
            drain(base, n, 2, 2, 0, 400);
            checks += 6;
            if (timed_out) begin errors++; $display("FAIL rand%0d_timeout got=no_done exp=done", it); end
            if (obs_addr.size() != n) begin errors++; $display("FAIL rand%0d_writes got=%0d exp=%0d", it, obs_addr.size(), n); end
            if (pops != n) begin errors++; $display("FAIL rand%0d_pops got=%0d exp=%0d", it, pops, n); end
            if (dones != 1) begin errors++; $display("FAIL rand%0d_dones got=%0d exp=1", it, dones); end
            if (rd_bad != 0 || wen_bad != 0) begin errors++; $display("FAIL rand%0d_protocol got=%0d/%0d exp=0/0", it, rd_bad, wen_bad); end
            if (obs_cyc.size() == n && done_cyc != obs_cyc[n-1] + 1) begin errors++; $display("FAIL rand%0d_done_cycle got=%0d exp=%0d", it, done_cyc, obs_cyc[n-1] + 1); end
            for (int i = 0; i < obs_addr.size() && i < n; i++) begin
                checks += 2;
                if (obs_addr[i] != exp_addr(base, i)) begin errors++; $display("FAIL rand%0d_addr%0d got=%h exp=%h", it, i, obs_addr[i], exp_addr(base, i)); end
                if (obs_data[i] !== exp_row(rows[i])) begin errors++; $display("FAIL rand%0d_data%0d got=%h exp=%h", it, i, obs_data[i], exp_row(rows[i])); end
            end
        end
    endtask

    initial begin
        bus.ofifo_valid = 1'b0;
        bus.ofifo_out   = '0;
        test_reset();
        test_basic();
        test_zero();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_relu();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
